// File: rtl/adder_wrapper.sv
// adder_wrapper: multi-limb add/subtract of two bus-selected operands, lo and up result streams
// Latency: limb sampled at edge t is on the outputs after edge t+2; extension limb follows the last limb
// Backpressure: none; every valid input limb is accepted, input gaps pass through as output gaps
module adder_wrapper #(
    parameter int g_data_width = 64,
    parameter int g_addr_width = 9,
    parameter int g_ctrl_width = 8,
    parameter int g_id         = 3
) (
    input  logic                    pi_clk,
    input  logic                    pi_rst,
    input  logic [g_ctrl_width-1:0] pi_ctrl_ch_A,
    input  logic [g_ctrl_width-1:0] pi_ctrl_ch_B,
    input  logic                    pi_ctrl_valid_n,
    input  logic                    pi_data_last,
    input  logic                    pi_data_wr_en,
    input  logic [g_data_width-1:0] pi_data_0,
    input  logic [g_data_width-1:0] pi_data_1,
    input  logic [g_data_width-1:0] pi_data_2,
    input  logic [g_data_width-1:0] pi_data_3,
    input  logic [g_data_width-1:0] pi_data_4,
    input  logic [g_data_width-1:0] pi_data_5,
    input  logic [g_data_width-1:0] pi_data_6,
    input  logic [g_data_width-1:0] pi_data_7,
    input  logic [g_data_width-1:0] pi_data_8,
    input  logic [g_data_width-1:0] pi_data_9,
    input  logic [g_data_width-1:0] pi_data_10,
    input  logic [g_data_width-1:0] pi_data_11,
    input  logic [g_data_width-1:0] pi_data_12,
    output logic [g_data_width-1:0] po_data_lo,
    output logic [g_data_width-1:0] po_data_up,
    output logic                    po_data_last,
    output logic                    po_data_wr_en,
    output logic                    po_data_all_ones,
    output logic [1:0]              po_data_zero
);

    // The register-file address width has no role in this unit; the empty
    // block only keeps the parameter referenced for lint.
    if (g_addr_width < 1) begin : g_addr_width_unused
    end

    localparam logic [5:0] ID6 = 6'(g_id);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_RUN, S_EXT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    take_frame;
    logic                    abort;
    logic                    id_hit;

    logic                    oper;          // 1 = subtract
    logic [g_ctrl_width-1:0] src_a;
    logic [g_ctrl_width-1:0] src_b;
    logic [1:0]              ext_cnt;

    // Operand bus array; slots 13..15 are constant zero so any index >12 reads 0.
    logic [g_data_width-1:0] bus [16];
    logic [g_data_width-1:0] op_a;
    logic [g_data_width-1:0] op_b;

    // Stage 1: captured operands
    logic                    s1_vld;
    logic                    s1_last;
    logic [g_data_width-1:0] s1_a;
    logic [g_data_width-1:0] s1_b;

    // Stage 2: computed limbs and carry/borrow chains
    logic                    c_lo;
    logic                    c_up;
    logic                    ext_pend;
    logic                    r_vld;
    logic                    r_last;
    logic [g_data_width-1:0] r_lo;
    logic [g_data_width-1:0] r_up;
    logic [g_data_width:0]   sum_lo;
    logic [g_data_width:0]   sum_up;

    // Output-side zero trackers over the whole stream
    logic                    z_lo;
    logic                    z_up;

    assign bus[0]  = pi_data_0;
    assign bus[1]  = pi_data_1;
    assign bus[2]  = pi_data_2;
    assign bus[3]  = pi_data_3;
    assign bus[4]  = pi_data_4;
    assign bus[5]  = pi_data_5;
    assign bus[6]  = pi_data_6;
    assign bus[7]  = pi_data_7;
    assign bus[8]  = pi_data_8;
    assign bus[9]  = pi_data_9;
    assign bus[10] = pi_data_10;
    assign bus[11] = pi_data_11;
    assign bus[12] = pi_data_12;
    assign bus[13] = '0;
    assign bus[14] = '0;
    assign bus[15] = '0;

    assign op_a = (src_a < g_ctrl_width'(13)) ? bus[src_a[3:0]] : '0;
    assign op_b = (src_b < g_ctrl_width'(13)) ? bus[src_b[3:0]] : '0;

    assign id_hit = !pi_ctrl_valid_n && (pi_ctrl_ch_A[5:0] == ID6);

    // State register
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a matching frame outside IDLE restarts the operation
    always_comb begin
        state_nxt  = state;
        take_frame = 1'b0;
        abort      = 1'b0;
        if (state != S_IDLE && id_hit) begin
            take_frame = 1'b1;
            abort      = 1'b1;
            state_nxt  = S_SEL;
        end else begin
            case (state)
                S_IDLE: if (id_hit) begin
                    take_frame = 1'b1;
                    state_nxt  = S_SEL;
                end
                S_SEL:  state_nxt = S_RUN;
                S_RUN:  if (pi_data_wr_en && pi_data_last) state_nxt = S_EXT;
                // Stay until the extension limb has reached the outputs
                S_EXT:  if (ext_cnt == 2'd2) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame fields: operation from word 0, source indices from word 1
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            oper    <= 1'b0;
            src_a   <= '0;
            src_b   <= '0;
            ext_cnt <= 2'd0;
        end else begin
            if (take_frame) oper <= pi_ctrl_ch_A[6];
            if (state == S_SEL && !abort) begin
                src_a <= pi_ctrl_ch_A;
                src_b <= pi_ctrl_ch_B;
            end
            if (state == S_EXT && state_nxt == S_EXT) ext_cnt <= ext_cnt + 2'd1;
            else                                      ext_cnt <= 2'd0;
        end
    end

    // Stage 1: capture the selected operand limbs
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else begin
            s1_vld  <= (state == S_RUN) && pi_data_wr_en && !abort;
            s1_last <= (state == S_RUN) && pi_data_wr_en && pi_data_last && !abort;
            s1_a    <= op_a;
            s1_b    <= op_b;
        end
    end

    // Limb arithmetic; bit g_data_width of each sum is the outgoing carry/borrow
    always_comb begin
        sum_lo = '0;
        sum_up = '0;
        if (oper) begin
            sum_lo = {1'b0, s1_a} - {1'b0, s1_b} - {{g_data_width{1'b0}}, c_lo};
            sum_up = {1'b0, s1_b} - {1'b0, s1_a} - {{g_data_width{1'b0}}, c_up};
        end else begin
            sum_lo = {1'b0, s1_a} + {1'b0, s1_b} + {{g_data_width{1'b0}}, c_lo};
            sum_up = {1'b0, s1_a} + {1'b0, s1_b} + {{g_data_width{1'b0}}, c_up};
        end
    end

    // Stage 2: register result limbs, hold chains across gaps, then emit the extension limb
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            c_lo     <= 1'b0;
            c_up     <= 1'b0;
            ext_pend <= 1'b0;
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
            r_lo     <= '0;
            r_up     <= '0;
        end else if (abort || state == S_SEL) begin
            c_lo     <= 1'b0;
            c_up     <= 1'b0;
            ext_pend <= 1'b0;
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
        end else if (s1_vld) begin
            c_lo     <= sum_lo[g_data_width];
            c_up     <= sum_up[g_data_width];
            ext_pend <= s1_last;
            r_vld    <= 1'b1;
            r_last   <= 1'b0;
            r_lo     <= sum_lo[g_data_width-1:0];
            r_up     <= sum_up[g_data_width-1:0];
        end else if (ext_pend) begin
            ext_pend <= 1'b0;
            r_vld    <= 1'b1;
            r_last   <= 1'b1;
            r_lo     <= oper ? {g_data_width{c_lo}} : {{(g_data_width-1){1'b0}}, c_lo};
            r_up     <= oper ? {g_data_width{c_up}} : {{(g_data_width-1){1'b0}}, c_up};
        end else begin
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
        end
    end

    // Output registers and status flags; flags are only raised with the final limb
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            po_data_lo       <= '0;
            po_data_up       <= '0;
            po_data_last     <= 1'b0;
            po_data_wr_en    <= 1'b0;
            po_data_all_ones <= 1'b0;
            po_data_zero     <= 2'b00;
            z_lo             <= 1'b0;
            z_up             <= 1'b0;
        end else if (abort) begin
            po_data_lo       <= '0;
            po_data_up       <= '0;
            po_data_last     <= 1'b0;
            po_data_wr_en    <= 1'b0;
            po_data_all_ones <= 1'b0;
            po_data_zero     <= 2'b00;
            z_lo             <= 1'b1;
            z_up             <= 1'b1;
        end else begin
            po_data_wr_en    <= r_vld;
            po_data_lo       <= r_vld ? r_lo : '0;
            po_data_up       <= r_vld ? r_up : '0;
            po_data_last     <= r_vld && r_last;
            po_data_all_ones <= r_vld && r_last && (&r_lo);
            po_data_zero     <= (r_vld && r_last) ? {z_up && (r_up == '0), z_lo && (r_lo == '0)} : 2'b00;
            if (state == S_SEL) begin
                z_lo <= 1'b1;
                z_up <= 1'b1;
            end else if (r_vld) begin
                z_lo <= z_lo && (r_lo == '0);
                z_up <= z_up && (r_up == '0);
            end
        end
    end

endmodule

// File: tb/tb_adder_wrapper.sv
// Directed bench for adder_wrapper: table of multi-limb vectors plus hand sequences
// for ID mismatch, abort, reset mid-stream and a long equal-operand subtract.
module tb_adder_wrapper;
    localparam int W  = 64;
    localparam int CW = 8;
    localparam logic [5:0] G_ID = 6'd3;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    typedef struct packed {
        logic               sub;
        logic [7:0]         sa;
        logic [7:0]         sb;
        logic [2:0]         n;
        logic [1:0]         gap;
        logic [1:0]         pre;
        logic [3:0][W-1:0]  a;
        logic [3:0][W-1:0]  b;
        logic [4:0][W-1:0]  lo;
        logic [4:0][W-1:0]  up;
        logic               all1;
        logic [1:0]         zero;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] ch_a;
    logic [CW-1:0] ch_b;
    logic          valid_n;
    logic          d_last;
    logic          d_wr_en;
    logic [W-1:0]  bus [13];
    logic [W-1:0]  o_lo;
    logic [W-1:0]  o_up;
    logic          o_last;
    logic          o_wr_en;
    logic          o_all1;
    logic [1:0]    o_zero;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    vec_t tab [8];

    adder_wrapper #(.g_data_width(W), .g_addr_width(9), .g_ctrl_width(CW), .g_id(3)) dut (
        .pi_clk(clk), .pi_rst(rst),
        .pi_ctrl_ch_A(ch_a), .pi_ctrl_ch_B(ch_b), .pi_ctrl_valid_n(valid_n),
        .pi_data_last(d_last), .pi_data_wr_en(d_wr_en),
        .pi_data_0(bus[0]), .pi_data_1(bus[1]), .pi_data_2(bus[2]), .pi_data_3(bus[3]),
        .pi_data_4(bus[4]), .pi_data_5(bus[5]), .pi_data_6(bus[6]), .pi_data_7(bus[7]),
        .pi_data_8(bus[8]), .pi_data_9(bus[9]), .pi_data_10(bus[10]), .pi_data_11(bus[11]),
        .pi_data_12(bus[12]),
        .po_data_lo(o_lo), .po_data_up(o_up), .po_data_last(o_last),
        .po_data_wr_en(o_wr_en), .po_data_all_ones(o_all1), .po_data_zero(o_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_buses;
        for (int j = 0; j < 13; j++) bus[j] = {$urandom, $urandom};
    endtask

    task automatic send_frame(input logic [5:0] id, input logic sub, input logic [7:0] sa, input logic [7:0] sb);
        valid_n = 1'b0; ch_a = {1'b0, sub, id}; ch_b = 8'hFF;
        tick();
        valid_n = 1'b1; ch_a = sa; ch_b = sb;
        tick();
        ch_a = '0; ch_b = '0;
    endtask

    task automatic drive_limb(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [7:0] sa, input logic [7:0] sb, input logic last);
        int ia;
        int ib;
        ia = int'(sa);
        ib = int'(sb);
        junk_buses();
        if (ia < 13) bus[ia] = a;
        if (ib < 13) bus[ib] = b;
        d_wr_en = 1'b1; d_last = last;
        tick();
        d_wr_en = 1'b0; d_last = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  t_last;
        int  got;
        int  gaps;
        int  noise;
        int  tmo;
        int  n;
        bit  done;
        n = int'(v.n);
        t_last = 0; got = 0; gaps = 0; noise = 0; done = 1'b0;
        tick();
        fork
            begin
                if (v.pre != 2'd0) begin
                    send_frame(G_ID, 1'b1, 8'd1, 8'd2);
                    for (int i = 0; i < int'(v.pre); i++)
                        drive_limb(64'h5A5A, 64'h1, 8'd1, 8'd2, 1'b0);
                end
                send_frame(G_ID, v.sub, v.sa, v.sb);
                for (int i = 0; i < n; i++) begin
                    if (i == n - 1) t_last = cyc + 1;
                    drive_limb(v.a[i], v.b[i], v.sa, v.sb, i == n - 1);
                    if (i == 0) begin
                        for (int g = 0; g < int'(v.gap); g++) begin
                            junk_buses();
                            tick();
                        end
                    end
                end
            end
            begin
                tmo = 0;
                while (!done && tmo < 100) begin
                    @(negedge clk);
                    tmo++;
                    if (o_wr_en) begin
                        if (got <= n) begin
                            chk($sformatf("v%0d lo[%0d]", idx, got), o_lo, v.lo[got]);
                            chk($sformatf("v%0d up[%0d]", idx, got), o_up, v.up[got]);
                        end
                        if (o_last) begin
                            done = 1'b1;
                            chk($sformatf("v%0d last_index", idx), 64'(got), 64'(n));
                            chk($sformatf("v%0d last_cycle", idx), 64'(cyc), 64'(t_last + 3));
                            chk($sformatf("v%0d all_ones", idx), 64'(o_all1), 64'(v.all1));
                            chk($sformatf("v%0d zero", idx), 64'(o_zero), 64'(v.zero));
                        end else if (o_all1 || o_zero != 2'b00) begin
                            noise++;
                        end
                        got++;
                    end else begin
                        if (got > 0) gaps++;
                        if (o_last || o_all1 || o_zero != 2'b00) noise++;
                    end
                end
                chk($sformatf("v%0d finished", idx), 64'(done), 64'd1);
                chk($sformatf("v%0d output_gaps", idx), 64'(gaps), 64'(v.gap));
                chk($sformatf("v%0d flag_noise", idx), 64'(noise), 64'd0);
            end
        join
    endtask

    task automatic run_long;
        int  got;
        int  nz;
        int  t_last;
        int  last_at;
        int  tmo;
        bit  done;
        logic [1:0] zf;
        logic a1;
        logic [W-1:0] r;
        got = 0; nz = 0; t_last = 0; last_at = 0; done = 1'b0; zf = 2'b00; a1 = 1'b1;
        tick();
        fork
            begin
                send_frame(G_ID, 1'b1, 8'd6, 8'd6);
                for (int i = 0; i < 511; i++) begin
                    r = {$urandom, $urandom};
                    if (i == 510) t_last = cyc + 1;
                    drive_limb(r, r, 8'd6, 8'd6, i == 510);
                end
            end
            begin
                tmo = 0;
                while (!done && tmo < 700) begin
                    @(negedge clk);
                    tmo++;
                    if (o_wr_en) begin
                        got++;
                        if (o_lo != '0 || o_up != '0) nz++;
                        if (o_last) begin
                            done = 1'b1;
                            zf = o_zero;
                            a1 = o_all1;
                            last_at = cyc;
                        end
                    end
                end
            end
        join
        chk("long finished", 64'(done), 64'd1);
        chk("long limb_count", 64'(got), 64'd512);
        chk("long nonzero_limbs", 64'(nz), 64'd0);
        chk("long zero", 64'(zf), 64'd3);
        chk("long all_ones", 64'(a1), 64'd0);
        chk("long last_cycle", 64'(last_at), 64'(t_last + 3));
    endtask

    initial begin
        vec_t v;
        int   cnt;

        // Vector table
        v = '0; v.sub = 1'b1; v.sa = 8'd2; v.sb = 8'd5; v.n = 3'd1;
        v.a[0] = 64'd5; v.b[0] = 64'd3;
        v.lo[0] = 64'd2; v.lo[1] = 64'd0;
        v.up[0] = 64'hFFFF_FFFF_FFFF_FFFE; v.up[1] = ONES;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[0] = v;

        v = '0; v.sub = 1'b1; v.sa = 8'd0; v.sb = 8'd12; v.n = 3'd1;
        v.a[0] = 64'd3; v.b[0] = 64'd5;
        v.lo[0] = 64'hFFFF_FFFF_FFFF_FFFE; v.lo[1] = ONES;
        v.up[0] = 64'd2; v.up[1] = 64'd0;
        v.all1 = 1'b1; v.zero = 2'b00;
        tab[1] = v;

        v = '0; v.sub = 1'b1; v.sa = 8'd7; v.sb = 8'd3; v.n = 3'd2;
        v.a[0] = 64'd0; v.a[1] = 64'd1; v.b[0] = 64'd1; v.b[1] = 64'd0;
        v.lo[0] = ONES; v.lo[1] = 64'd0; v.lo[2] = 64'd0;
        v.up[0] = 64'd1; v.up[1] = ONES; v.up[2] = ONES;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[2] = v;

        v = '0; v.sub = 1'b0; v.sa = 8'd1; v.sb = 8'd9; v.n = 3'd3;
        for (int i = 0; i < 3; i++) begin v.a[i] = ONES; v.b[i] = ONES; end
        v.lo[0] = 64'hFFFF_FFFF_FFFF_FFFE; v.lo[1] = ONES; v.lo[2] = ONES; v.lo[3] = 64'd1;
        v.up = v.lo;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[3] = v;

        v = '0; v.sub = 1'b0; v.sa = 8'd4; v.sb = 8'd20; v.n = 3'd1;
        v.a[0] = 64'd7; v.b[0] = 64'hDEAD;
        v.lo[0] = 64'd7; v.lo[1] = 64'd0; v.up = v.lo;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[4] = v;

        v = '0; v.sub = 1'b0; v.sa = 8'd13; v.sb = 8'd255; v.n = 3'd2;
        v.a[0] = 64'd11; v.a[1] = 64'd12; v.b[0] = 64'd13; v.b[1] = 64'd14;
        v.all1 = 1'b0; v.zero = 2'b11;
        tab[5] = v;

        v = '0; v.sub = 1'b0; v.sa = 8'd10; v.sb = 8'd11; v.n = 3'd2; v.gap = 2'd2;
        v.a[0] = 64'd1; v.a[1] = 64'd2; v.b[0] = ONES; v.b[1] = 64'd0;
        v.lo[0] = 64'd0; v.lo[1] = 64'd3; v.lo[2] = 64'd0; v.up = v.lo;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[6] = v;

        v = '0; v.sub = 1'b1; v.sa = 8'd8; v.sb = 8'd0; v.n = 3'd1; v.pre = 2'd2;
        v.a[0] = 64'd9; v.b[0] = 64'd4;
        v.lo[0] = 64'd5; v.lo[1] = 64'd0;
        v.up[0] = 64'hFFFF_FFFF_FFFF_FFFB; v.up[1] = ONES;
        v.all1 = 1'b0; v.zero = 2'b00;
        tab[7] = v;

        // Reset
        rst = 1'b1; valid_n = 1'b1; ch_a = '0; ch_b = '0; d_last = 1'b0; d_wr_en = 1'b0;
        for (int j = 0; j < 13; j++) bus[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset lo", o_lo, '0);
        chk("reset up", o_up, '0);
        chk("reset wr_en", 64'(o_wr_en), 64'd0);
        chk("reset last", 64'(o_last), 64'd0);
        chk("reset all_ones", 64'(o_all1), 64'd0);
        chk("reset zero", 64'(o_zero), 64'd0);

        // Frame for another unit: data must be ignored
        cnt = 0;
        fork
            begin
                send_frame(G_ID + 6'd1, 1'b0, 8'd1, 8'd2);
                for (int i = 0; i < 3; i++) drive_limb(64'd1, 64'd1, 8'd1, 8'd2, i == 2);
            end
            begin
                repeat (15) begin
                    @(negedge clk);
                    if (o_wr_en) cnt++;
                end
            end
        join
        chk("bad_id no_output", 64'(cnt), 64'd0);

        for (int k = 0; k < 8; k++) run_vec(tab[k], k);

        run_long();

        // Reset while results are streaming out
        tick();
        send_frame(G_ID, 1'b0, 8'd1, 8'd2);
        for (int i = 0; i < 6; i++) drive_limb(64'h10 + 64'(i), 64'h1, 8'd1, 8'd2, 1'b0);
        chk("midreset busy_before", 64'(o_wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("midreset wr_en", 64'(o_wr_en), 64'd0);
        chk("midreset lo", o_lo, '0);
        chk("midreset up", o_up, '0);
        tick();
        rst = 1'b0;
        run_vec(tab[0], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
